// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I sequencer: FETCH -> DECODE -> EXECUTE -> MEM -> WB with
// ready-handshaked memory, a bounded-wait watchdog and a sticky trap state.
module multicycle_control_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic [1:0] alu_op,
    output logic       alu_src_imm,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       retired,
    output logic       trap,
    output logic [1:0] trap_cause
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } iclass_t;

    state_t           state_q, state_d;
    iclass_t          cls_q, cls_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;

    iclass_t          dec_cls;
    logic [1:0]       dec_cause;
    logic             req_phase;
    logic             wd_expired;

    assign req_phase  = (state_q == S_FETCH) || (state_q == S_MEM);
    assign wd_expired = req_phase && !mem_ready
                        && (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        dec_cls   = C_R;
        dec_cause = 2'd0;
        case (opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: begin
                dec_cls = C_LOAD;
                if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)
                    dec_cause = 2'd1;
            end
            7'b0100011: begin
                dec_cls = C_STORE;
                if (funct3 > 3'd2)
                    dec_cause = 2'd1;
            end
            7'b1100011: dec_cls = C_BRANCH;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1110011: dec_cause = 2'd3;
            default:    dec_cause = 2'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wd_expired) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd2;
                end
            end
            S_DECODE: begin
                if (dec_cause != 2'd0) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = dec_cause;
                end else begin
                    state_d = S_EXECUTE;
                    cls_d   = dec_cls;
                end
            end
            S_EXECUTE: begin
                if (cls_q == C_BRANCH)
                    state_d = S_FETCH;
                else if (cls_q == C_LOAD || cls_q == C_STORE)
                    state_d = S_MEM;
                else
                    state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
                end else if (wd_expired) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'd2;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase

        // Watchdog only runs while a request is stalled inside one state.
        if (state_d != state_q || mem_ready || !req_phase)
            wd_d = '0;
        else
            wd_d = wd_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cls_q   <= C_R;
            wd_q    <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wd_q    <= wd_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Gated by rst_n so an asserted reset drops the bus request immediately.
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        wb_sel       = 2'd0;
        alu_op       = 2'd0;
        alu_src_imm  = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'd0;
        retired      = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                S_EXECUTE: begin
                    case (cls_q)
                        C_R: alu_op = 2'd2;
                        C_I: begin
                            alu_op      = 2'd2;
                            alu_src_imm = 1'b1;
                        end
                        C_LOAD, C_STORE, C_AUIPC, C_JALR: begin
                            alu_op      = 2'd0;
                            alu_src_imm = 1'b1;
                        end
                        C_BRANCH: begin
                            alu_op   = 2'd1;
                            pc_write = 1'b1;
                            retired  = 1'b1;
                            pc_src   = branch_taken ? 2'd1 : 2'd0;
                        end
                        C_LUI: begin
                            alu_op      = 2'd3;
                            alu_src_imm = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls_q == C_STORE);
                    if (cls_q == C_STORE && mem_ready) begin
                        pc_write = 1'b1;
                        retired  = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retired   = 1'b1;
                    case (cls_q)
                        C_LOAD: wb_sel = 2'd1;
                        C_JAL: begin
                            wb_sel = 2'd2;
                            pc_src = 2'd1;
                        end
                        C_JALR: begin
                            wb_sel = 2'd2;
                            pc_src = 2'd2;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle sequencer for the RV32I core. It consumes the opcode/funct3 fields produced by instruction_decoder and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB. It emits one-cycle strobes for the PC, IR, register bank and memory port, and handles a ready-handshaked memory plus a bounded-wait watchdog. It sits between instruction_decoder and the datapath (PC/IR registers, register bank, ALU, memory interface).

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may stay asserted without mem_ready before trapping (>=2)
CNT_W, 5, watchdog counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  7  from instruction_decoder, valid from DECODE onward
funct3  input  3  from instruction_decoder
branch_taken  input  1  ALU compare result, sampled in EXECUTE of branches
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request (fetch or data)
mem_we  output  1  write enable, only with mem_req in MEM of stores
mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result (data)
ir_write  output  1  load IR, one-cycle pulse
reg_write  output  1  register bank write, one-cycle pulse
wb_sel  output  2  0 ALU, 1 memory data, 2 PC+4
alu_op  output  2  0 add, 1 branch compare, 2 funct-decoded, 3 pass imm
alu_src_imm  output  1  ALU operand B = imm
pc_write  output  1  update PC, one-cycle pulse, once per retired instruction
pc_src  output  2  0 PC+4, 1 PC+imm, 2 (rs1+imm)&~1
retired  output  1  pulse coincident with pc_write
trap  output  1  sticky halt flag
trap_cause  output  2  0 none, 1 illegal opcode, 2 memory timeout, 3 SYSTEM

Behaviour:
- Reset (async, rst_n=0): state=FETCH, watchdog=0, trap=0, trap_cause=0, all strobes 0, wb_sel=0, alu_op=0, pc_src=0, mem_addr_sel=0. The first fetch request starts the first cycle after rst_n rises. Reset mid-instruction aborts it with no write.
- FETCH: mem_req=1, mem_addr_sel=0. When mem_ready=1, pulse ir_write and go to DECODE.
- DECODE: 1 cycle, no strobes. Classify opcode:
  R=0110011, I=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111 -> EXECUTE.
  SYSTEM=1110011 -> TRAP, cause 3. Any other value -> TRAP, cause 1.
- EXECUTE: 1 cycle. alu_op/alu_src_imm per class: R = 2/0; I = 2/1; LOAD/STORE/AUIPC/JALR = 0/1; BRANCH = 1/0; LUI = 3/1.
  - BRANCH: pc_write=1, retired=1, pc_src = branch_taken ? 1 : 0, then FETCH.
  - LOAD/STORE -> MEM. All others -> WB.
- MEM: mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only.
  - STORE retires (pc_write, pc_src=0) in the mem_ready cycle, then FETCH.
  - LOAD goes to WB on mem_ready.
- WB: 1 cycle, reg_write=1.
  - wb_sel: LOAD 1; JAL/JALR 2; others 0.
  - pc_write=1, retired=1.
  - pc_src: JAL 1, JALR 2, else 0.
  - Then FETCH.
- Zero-wait latency, counted in cycles from FETCH entry to retire: BRANCH 3; STORE 4; R/I/LUI/AUIPC/JAL/JALR 4; LOAD 5. Each wait cycle on mem_ready adds one cycle.
- funct3 is used only to qualify the load/store width: funct3 in {3,6,7} for LOAD, or >2 for STORE, is treated as illegal -> TRAP, cause 1, decided in DECODE.
- Watchdog:
  - Counts cycles with mem_req=1 and mem_ready=0; clears on mem_ready or state change.
  - When the count reaches TIMEOUT_CYCLES-1 without mem_ready, the next edge enters TRAP with cause 2.
  - mem_ready arriving on the terminal cycle wins: it completes normally.
- TRAP: absorbing until reset. All strobes 0, trap=1, trap_cause held. No write of any kind on the transition into TRAP.
- Strobes are Moore outputs of state/class, except ir_write, the fetch/store retire and the LOAD→WB transition, which are qualified by mem_ready in the same cycle.
- Invariant: at most one of ir_write, reg_write, mem_we is high per cycle.

Test Plan:
- R-type 0x001F1B3, mem_ready tied 1 -> ir_write at cycle 1, reg_write+pc_write+retired at cycle 4, wb_sel=0, alu_op=2, pc_src=0.
- LOAD 0x001F183 with a 3-cycle data wait -> funct3=7 traps (cause 1, no reg_write). Repeat with 0x0012183 (funct3=2): retire at cycle 8, wb_sel=1.
- BRANCH 0x001F1E3 with branch_taken=1 then 0 -> pc_write at cycle 3 with pc_src=1, then 0. reg_write never asserted.
- JAL 0x001F1EF and JALR 0x001F167 -> WB with wb_sel=2, pc_src=1 and pc_src=2 respectively. SYSTEM 0x001F1F3 -> trap=1, cause 3, all strobes 0 thereafter.
- Fetch with mem_ready held 0 -> trap cause 2 after exactly 16 cycles of mem_req. Second run with mem_ready on cycle 16 -> normal decode, no trap.
- Assert rst_n=0 mid-MEM of a store (async, between edges) -> mem_req/mem_we drop immediately. After release, a fetch restarts and trap=0.
